// File: rtl/dmem_responder.sv
// Data-memory responder: one LOAD/STORE at a time, fixed latency, one-cycle ack.
// Optional out-of-range detection: define DMEM_RANGE_CHECK_EN.
package simple_processor_pkg;
  parameter int ADDR_WIDTH = 32;
  parameter int DATA_WIDTH = 32;
endpackage

module dmem_responder #(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  dmem_req_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic                  dmem_we_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_ack_o,
  output logic                  dmem_err_o
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  enter_ack;
  logic                  oob;
  logic                  mem_we;
  logic [IDXW-1:0]       idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    enter_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dmem_req_i) begin
          addr_d  = dmem_addr_i;
          we_d    = dmem_we_i;
          wdata_d = dmem_wdata_i;
          if (LATENCY == 1) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNTW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The op uses the _d view so LATENCY==1 sees the request captured this edge.
  assign idx = addr_d[IDXW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign oob = |(addr_d >> IDXW);
`else
  assign oob = 1'b0;
`endif

  assign mem_we = enter_ack & we_d & ~oob;

  always_comb begin
    ack_d   = enter_ack;
    err_d   = enter_ack & oob;
    rdata_d = rdata_q;
    if (enter_ack && !we_d) begin
      rdata_d = oob ? '0 : mem[idx];
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx] <= wdata_d;
    end
  end

  assign dmem_rdata_o = rdata_q;
  assign dmem_ack_o   = ack_q;
  assign dmem_err_o   = err_q;

endmodule
